multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (even, >= 8).
REQ-002 SHALL have derived localparam SHW = $clog2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clk_i, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port start_i, input, 1, operation request; sampled only in IDLE.
REQ-006 SHALL have port ALUctl_i, input, 4, operation select (encoding in REQ-015).
REQ-007 SHALL have port A_i, input, WIDTH, operand A.
REQ-008 SHALL have port B_i, input, WIDTH, operand B.
REQ-009 SHALL have port shamt_i, input, SHW, immediate shift amount.
REQ-010 SHALL have port ready_o, output, 1, high exactly when in IDLE.
REQ-011 SHALL have port done_o, output, 1, one-cycle pulse marking a new valid result.
REQ-012 SHALL have port ALUOut_o, output, WIDTH, registered result (low half for multiply, quotient for divide).
REQ-013 SHALL have port hi_o, output, WIDTH, registered upper product or remainder; 0 for all other ops.
REQ-014 SHALL have port Zero_o, output, 1, registered (ALUOut_o == 0), updated together with ALUOut_o.

Function
REQ-015 SHALL decode ALUctl_i as follows, all unsigned:
- 0: A&B
- 1: A|B
- 2: A+B (mod 2^WIDTH)
- 3: B >> A[SHW-1:0]
- 4: B >> shamt
- 5: B << (WIDTH/2)
- 6: A-B
- 7: (A<B)?1:0
- 8: A | zero-extended B[WIDTH/2-1:0]
- 9: (A==B)?1:0
- 10: sequential multiply
- 11: A
- 12: sequential divide (REQ-027)
- 13-15: result 0
REQ-016 SHALL implement the states IDLE, MUL, DIV and DONE.
REQ-017 In IDLE, start_i=1 SHALL latch ALUctl_i, A_i, B_i and shamt_i in the same edge.
REQ-018 Single-cycle ops (all except 10 and 12) SHALL go IDLE->DONE; results are written at the start edge and done_o=1 in the following cycle (latency 1).
REQ-019 Op 10 SHALL go IDLE->MUL and run a shift-add multiply for exactly WIDTH cycles, then go to DONE with the full 2*WIDTH-bit product: hi_o = upper half, ALUOut_o = lower half; latency WIDTH+1.
REQ-020 DONE SHALL last one cycle with done_o=1 and ready_o=0, then return to IDLE.
REQ-021 ALUOut_o, hi_o and Zero_o SHALL hold their value from the last DONE until the next result write; intermediate iteration values SHALL NOT appear on them.
REQ-022 start_i SHALL be ignored outside IDLE; a start asserted during DONE is not queued.
REQ-023 Back-to-back: with start_i held high, a new op SHALL be accepted in the IDLE cycle after each DONE (single-cycle op throughput = one per 2 cycles).
REQ-024 Operand changes on A_i, B_i, ALUctl_i or shamt_i after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-025 While rst_i=1 at a clock edge, the block SHALL enter IDLE and set ALUOut_o=0, hi_o=0, Zero_o=1, done_o=0 and ready_o=1 after that edge.
REQ-026 Reset mid-MUL or mid-DIV SHALL abort the operation with no done_o pulse; the first post-reset start SHALL be accepted normally.

Configuration
REQ-027 With macro MULTICYCLE_ALU_DIV_EN defined, op 12 SHALL go IDLE->DIV and run a restoring divide for WIDTH cycles (ALUOut_o = A/B, hi_o = A%B, latency WIDTH+1). If B=0, it SHALL skip iteration and go directly to DONE with ALUOut_o = all-ones and hi_o = A (latency 1).
REQ-028 Without MULTICYCLE_ALU_DIV_EN, no divider logic SHALL be synthesised; op 12 SHALL behave as a single-cycle op with ALUOut_o=0, hi_o=0 and Zero_o=1.

Verification
REQ-029 Reset, then op 2 with A=0xFFFFFFFF and B=1 -> done_o one cycle after start; ALUOut_o=0, Zero_o=1.
REQ-030 Op 10 with A=0xFFFFFFFF and B=0xFFFFFFFF (WIDTH=32) -> done_o exactly 33 cycles after start; hi_o=0xFFFFFFFE, ALUOut_o=0x00000001; ready_o=0 throughout.
REQ-031 Op 4 with B=0x80000000 and shamt=31 -> ALUOut_o=1. Op 3 with A=0x25 and B=0x80000000 -> ALUOut_o=0x04000000 (A[4:0]=5).
REQ-032 Op 10 started, then rst_i=1 at cycle 10 -> no done_o pulse; ALUOut_o=0; a following op 11 with A=0x1234 -> ALUOut_o=0x1234 after 1 cycle.
REQ-033 With DIV_EN: op 12 with A=100 and B=7 -> ALUOut_o=14, hi_o=2 after 33 cycles; op 12 with B=0 -> ALUOut_o=0xFFFFFFFF, hi_o=A after 1 cycle. Without DIV_EN: op 12 -> ALUOut_o=0 and Zero_o=1 after 1 cycle.
REQ-034 Start pulses during MUL with a changed A_i -> ignored; the product matches the operands latched at acceptance.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops, shift-add multiply over WIDTH cycles.
// Optional restoring divider (op 12) is enabled by defining MULTICYCLE_ALU_DIV_EN.
module multicycle_alu #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [3:0]       ALUctl_i,
   input  logic [WIDTH-1:0] A_i,
   input  logic [WIDTH-1:0] B_i,
   input  logic [SHW-1:0]   shamt_i,
   output logic             ready_o,
   output logic             done_o,
   output logic [WIDTH-1:0] ALUOut_o,
   output logic [WIDTH-1:0] hi_o,
   output logic             Zero_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

   state_t             state_r, state_s;
   logic [2*WIDTH-1:0] p_r, step_s;
   logic [WIDTH-1:0]   opnd_r;
   logic [SHW-1:0]     cnt_r;
   logic [WIDTH:0]     msum_s;
   logic               last_s, is_div_s;
`ifdef MULTICYCLE_ALU_DIV_EN
   logic [WIDTH:0]     dshift_s, ddiff_s;
`endif

   function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] ctl,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [SHW-1:0] sh);
      logic [WIDTH-1:0] r;
      case (ctl)
         4'd0:    r = a & b;
         4'd1:    r = a | b;
         4'd2:    r = a + b;
         4'd3:    r = b >> a[SHW-1:0];
         4'd4:    r = b >> sh;
         4'd5:    r = b << (WIDTH/2);
         4'd6:    r = a - b;
         4'd7:    r = (a < b) ? WIDTH'(1) : {WIDTH{1'b0}};
         4'd8:    r = a | {{(WIDTH/2){1'b0}}, b[WIDTH/2-1:0]};
         4'd9:    r = (a == b) ? WIDTH'(1) : {WIDTH{1'b0}};
         4'd11:   r = a;
         default: r = {WIDTH{1'b0}};
      endcase
      return r;
   endfunction

`ifdef MULTICYCLE_ALU_DIV_EN
   assign is_div_s = (ALUctl_i == 4'd12);
`else
   assign is_div_s = 1'b0;
`endif
   assign last_s = (cnt_r == SHW'(WIDTH-1));

   // One multiply (or divide) iteration on the packed {upper, lower} working register.
   always_comb begin
      msum_s = {1'b0, p_r[2*WIDTH-1:WIDTH]} + (p_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
      step_s = {msum_s, p_r[WIDTH-1:1]};
`ifdef MULTICYCLE_ALU_DIV_EN
      dshift_s = p_r[2*WIDTH-1:WIDTH-1];
      ddiff_s  = dshift_s - {1'b0, opnd_r};
      if (state_r == DIV) begin
         if (!ddiff_s[WIDTH]) begin
            step_s = {ddiff_s[WIDTH-1:0], p_r[WIDTH-2:0], 1'b1};
         end else begin
            step_s = {dshift_s[WIDTH-1:0], p_r[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_s = {msum_s, p_r[WIDTH-1:1]};
      end
`endif
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_i) begin
               if (ALUctl_i == 4'd10) begin
                  state_s = MUL;
               end else if (is_div_s && (B_i != {WIDTH{1'b0}})) begin
                  state_s = DIV;
               end else begin
                  state_s = DONE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         MUL, DIV: begin
            if (last_s) begin
               state_s = DONE;
            end else begin
               state_s = state_r;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Operand latching, iteration state and registered result outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         p_r      <= {(2*WIDTH){1'b0}};
         opnd_r   <= {WIDTH{1'b0}};
         cnt_r    <= {SHW{1'b0}};
         ALUOut_o <= {WIDTH{1'b0}};
         hi_o     <= {WIDTH{1'b0}};
         Zero_o   <= 1'b1;
         done_o   <= 1'b0;
         ready_o  <= 1'b1;
      end else begin
         done_o  <= (state_s == DONE);
         ready_o <= (state_s == IDLE);
         case (state_r)
            IDLE: begin
               if (start_i) begin
                  cnt_r <= {SHW{1'b0}};
                  if (ALUctl_i == 4'd10) begin
                     opnd_r <= A_i;
                     p_r    <= {{WIDTH{1'b0}}, B_i};
                  end else if (is_div_s && (B_i != {WIDTH{1'b0}})) begin
                     opnd_r <= B_i;
                     p_r    <= {{WIDTH{1'b0}}, A_i};
                  end else if (is_div_s) begin
                     // Divide by zero: saturated quotient, dividend as remainder.
                     ALUOut_o <= {WIDTH{1'b1}};
                     hi_o     <= A_i;
                     Zero_o   <= 1'b0;
                  end else begin
                     ALUOut_o <= alu_single(ALUctl_i, A_i, B_i, shamt_i);
                     hi_o     <= {WIDTH{1'b0}};
                     Zero_o   <= (alu_single(ALUctl_i, A_i, B_i, shamt_i) == {WIDTH{1'b0}});
                  end
               end
            end
            MUL, DIV: begin
               p_r   <= step_s;
               cnt_r <= cnt_r + SHW'(1);
               if (last_s) begin
                  ALUOut_o <= step_s[WIDTH-1:0];
                  hi_o     <= step_s[2*WIDTH-1:WIDTH];
                  Zero_o   <= (step_s[WIDTH-1:0] == {WIDTH{1'b0}});
               end
            end
            default: begin
               p_r <= p_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=32): random single-cycle ops, multiply,
// optional divide, reset abort and back-to-back throughput against a plain-arithmetic model.
module tb_multicycle_alu;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [3:0]  ALUctl_i = 4'd0;
   logic [31:0] A_i = 32'd0, B_i = 32'd0;
   logic [4:0]  shamt_i = 5'd0;
   logic        ready_o, done_o, Zero_o;
   logic [31:0] ALUOut_o, hi_o;

   int checks = 0;
   int failures = 0;

   multicycle_alu #(.WIDTH(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ALUctl_i(ALUctl_i),
      .A_i(A_i), .B_i(B_i), .shamt_i(shamt_i), .ready_o(ready_o), .done_o(done_o),
      .ALUOut_o(ALUOut_o), .hi_o(hi_o), .Zero_o(Zero_o));

   always #5 clk_i = ~clk_i;

   initial begin
      #3000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Reference result: {hi, lo} for any op, straight from the operation table.
   function automatic logic [63:0] ref_op(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] s);
      logic [31:0] lo;
      case (c)
         4'd0:  lo = a & b;
         4'd1:  lo = a | b;
         4'd2:  lo = a + b;
         4'd3:  lo = b >> a[4:0];
         4'd4:  lo = b >> s;
         4'd5:  lo = b << 16;
         4'd6:  lo = a - b;
         4'd7:  lo = (a < b) ? 32'd1 : 32'd0;
         4'd8:  lo = a | {16'd0, b[15:0]};
         4'd9:  lo = (a == b) ? 32'd1 : 32'd0;
         4'd10: return {32'd0, a} * {32'd0, b};
         4'd11: lo = a;
`ifdef MULTICYCLE_ALU_DIV_EN
         4'd12: return (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
`endif
         default: lo = 32'd0;
      endcase
      return {32'd0, lo};
   endfunction

   // Issue one op when ready; returns cycles from accept edge to done and whether busy was clean.
   task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s, input bit scramble, output int lat, output bit busy_ok);
      int guard = 0;
      @(negedge clk_i);
      while (!ready_o && guard < 200) begin
         @(negedge clk_i);
         guard++;
      end
      start_i = 1'b1; ALUctl_i = c; A_i = a; B_i = b; shamt_i = s;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      A_i = $urandom; B_i = $urandom; shamt_i = 5'($urandom);
      lat = 1; busy_ok = 1'b1;
      while (!done_o && lat < 100) begin
         if (ready_o) busy_ok = 1'b0;
         if (scramble) begin
            start_i = 1'($urandom); A_i = $urandom; ALUctl_i = 4'($urandom);
         end
         @(posedge clk_i); #1;
         lat++;
      end
      start_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      checks++;
      if ({ALUOut_o, hi_o, Zero_o, done_o, ready_o} !== {32'd0, 32'd0, 1'b1, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset_state got out=%h hi=%h z=%b done=%b rdy=%b", ALUOut_o, hi_o, Zero_o, done_o, ready_o);
      end
      rst_i = 1'b0;
   endtask

   task automatic test_single();
      int lat; bit ok;
      logic [3:0] c; logic [31:0] a, b; logic [4:0] s; logic [63:0] e;
      for (int i = 0; i < 40; i++) begin
         if (i == 0) begin c = 4'd2; a = 32'hFFFF_FFFF; b = 32'd1; s = 5'd0; end
         else if (i == 1) begin c = 4'd4; a = 32'd0; b = 32'h8000_0000; s = 5'd31; end
         else if (i == 2) begin c = 4'd3; a = 32'h25; b = 32'h8000_0000; s = 5'd0; end
         else begin
            c = 4'($urandom_range(0, 15));
            while (c == 4'd10 || c == 4'd12) c = 4'($urandom_range(0, 15));
            a = $urandom; s = 5'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         end
         e = ref_op(c, a, b, s);
         if (i == 0) e = 64'd0;
         if (i == 1) e = 64'd1;
         if (i == 2) e = 64'h0400_0000;
         run_op(c, a, b, s, 1'b0, lat, ok);
         checks++;
         if (lat !== 1 || ALUOut_o !== e[31:0] || hi_o !== e[63:32] || Zero_o !== (e[31:0] == 32'd0)) begin
            failures++;
            $display("FAIL single op%0d lat=%0d out=%h hi=%h z=%b exp lat=1 out=%h hi=%h", c, lat, ALUOut_o, hi_o, Zero_o, e[31:0], e[63:32]);
         end
      end
   endtask

   task automatic test_mul();
      int lat; bit ok;
      logic [31:0] a, b; logic [63:0] e;
      for (int i = 0; i < 8; i++) begin
         a = (i == 0) ? 32'hFFFF_FFFF : (i == 1 ? 32'd0 : $urandom);
         b = (i == 0) ? 32'hFFFF_FFFF : $urandom;
         e = (i == 0) ? 64'hFFFF_FFFE_0000_0001 : ref_op(4'd10, a, b, 5'd0);
         run_op(4'd10, a, b, 5'd0, i >= 2, lat, ok);
         checks++;
         if (lat !== 33 || !ok || ALUOut_o !== e[31:0] || hi_o !== e[63:32] || Zero_o !== (e[31:0] == 32'd0)) begin
            failures++;
            $display("FAIL mul lat=%0d busy_ok=%b out=%h hi=%h exp lat=33 out=%h hi=%h", lat, ok, ALUOut_o, hi_o, e[31:0], e[63:32]);
         end
         @(posedge clk_i); #1;
         checks++;
         if (done_o !== 1'b0 || ready_o !== 1'b1 || ALUOut_o !== e[31:0] || hi_o !== e[63:32]) begin
            failures++;
            $display("FAIL mul_after done=%b rdy=%b out=%h exp done=0 rdy=1 out=%h", done_o, ready_o, ALUOut_o, e[31:0]);
         end
      end
   endtask

   task automatic test_div();
      int lat; bit ok;
      logic [31:0] a, b; logic [63:0] e;
`ifdef MULTICYCLE_ALU_DIV_EN
      for (int i = 0; i < 6; i++) begin
         a = (i == 0) ? 32'd100 : $urandom;
         b = (i == 0) ? 32'd7 : (i == 1 ? 32'd0 : ($urandom >> $urandom_range(0, 31)));
         e = (i == 0) ? {32'd2, 32'd14} : ref_op(4'd12, a, b, 5'd0);
         run_op(4'd12, a, b, 5'd0, 1'b0, lat, ok);
         checks++;
         if (lat !== ((b == 32'd0) ? 1 : 33) || ALUOut_o !== e[31:0] || hi_o !== e[63:32]) begin
            failures++;
            $display("FAIL div lat=%0d out=%h hi=%h exp out=%h hi=%h", lat, ALUOut_o, hi_o, e[31:0], e[63:32]);
         end
      end
`else
      a = $urandom; b = $urandom | 32'd1;
      run_op(4'd12, a, b, 5'd0, 1'b0, lat, ok);
      checks++;
      if (lat !== 1 || ALUOut_o !== 32'd0 || hi_o !== 32'd0 || Zero_o !== 1'b1) begin
         failures++;
         $display("FAIL div_disabled lat=%0d out=%h hi=%h z=%b exp lat=1 out=0 hi=0 z=1", lat, ALUOut_o, hi_o, Zero_o);
      end
`endif
   endtask

   task automatic test_reset_mid_mul();
      int lat; bit ok; bit saw_done = 1'b0;
      run_op(4'd2, 32'd5, 32'd6, 5'd0, 1'b0, lat, ok);
      @(negedge clk_i);
      @(negedge clk_i);
      start_i = 1'b1; ALUctl_i = 4'd10; A_i = 32'h1234_5678; B_i = 32'h9ABC_DEF0;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (9) begin
         @(posedge clk_i); #1;
         if (done_o) saw_done = 1'b1;
      end
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      checks++;
      if (saw_done || done_o !== 1'b0 || ALUOut_o !== 32'd0 || hi_o !== 32'd0 || Zero_o !== 1'b1 || ready_o !== 1'b1) begin
         failures++;
         $display("FAIL mul_abort saw_done=%b done=%b out=%h hi=%h z=%b rdy=%b exp 0 0 0 0 1 1", saw_done, done_o, ALUOut_o, hi_o, Zero_o, ready_o);
      end
      repeat (30) begin
         @(posedge clk_i); #1;
         if (done_o) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         failures++;
         $display("FAIL mul_abort_late got done pulse after reset exp none");
      end
      run_op(4'd11, 32'h1234, 32'd0, 5'd0, 1'b0, lat, ok);
      checks++;
      if (lat !== 1 || ALUOut_o !== 32'h1234) begin
         failures++;
         $display("FAIL post_reset_op lat=%0d out=%h exp lat=1 out=00001234", lat, ALUOut_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v [0:11];
      int guard = 0;
      @(negedge clk_i);
      while (!ready_o && guard < 200) begin
         @(negedge clk_i);
         guard++;
      end
      start_i = 1'b1; ALUctl_i = 4'd11;
      for (int k = 0; k < 12; k++) begin
         v[k] = $urandom;
         A_i = v[k];
         @(posedge clk_i); #1;
         checks++;
         if ((k % 2) == 0) begin
            if (done_o !== 1'b1 || ready_o !== 1'b0 || ALUOut_o !== v[k]) begin
               failures++;
               $display("FAIL b2b_accept k=%0d done=%b rdy=%b out=%h exp 1 0 %h", k, done_o, ready_o, ALUOut_o, v[k]);
            end
         end else begin
            if (done_o !== 1'b0 || ready_o !== 1'b1 || ALUOut_o !== v[k-1]) begin
               failures++;
               $display("FAIL b2b_ignore k=%0d done=%b rdy=%b out=%h exp 0 1 %h", k, done_o, ready_o, ALUOut_o, v[k-1]);
            end
         end
         @(negedge clk_i);
      end
      start_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_mul();
      test_div();
      test_reset_mid_mul();
      test_back_to_back();
      repeat (3) @(posedge clk_i);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
